h3_hash_multi: RTL and testbench



---
 rtl/h3_pkg.sv | 20 ++
 rtl/h3_group_xor.sv | 24 ++
 rtl/h3_hash_multi.sv | 158 +++++++++++++++
 tb/tb_h3_hash_multi.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h3_pkg.sv
// Shared defaults and helpers for the multi-hash H3 unit.
// Optional feature macro used by the top level: H3_PARITY_EN.
package h3_pkg;

    localparam int DEF_INPUT_WIDTH = 28;
    localparam int DEF_HASH_WIDTH  = 8;
    localparam int DEF_NUM_HASHES  = 2;
    localparam int DEF_GROUP_SIZE  = 7;

    // Groups needed to cover the input word; the last group may be short.
    localparam int NUM_GROUPS = (DEF_INPUT_WIDTH + DEF_GROUP_SIZE - 1) / DEF_GROUP_SIZE;

    typedef logic [DEF_HASH_WIDTH-1:0] hash_t;

    // $clog2 that never yields a zero-width select field.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/h3_group_xor.sv
// Masked XOR of one group of input bits for one hash function.
// Padding bits of a short last group arrive as zero and contribute nothing.
module h3_group_xor
    import h3_pkg::*;
#(
    parameter int HASH_WIDTH = DEF_HASH_WIDTH,
    parameter int GROUP_SIZE = DEF_GROUP_SIZE
) (
    input  logic [GROUP_SIZE-1:0]            bits,
    input  logic [GROUP_SIZE*HASH_WIDTH-1:0] params,
    output logic [HASH_WIDTH-1:0]            partial
);

    // XOR the parameter row of every set input bit in this group.
    always_comb begin
        partial = '0;
        for (int k = 0; k < GROUP_SIZE; k++) begin
            if (bits[k]) begin
                partial = partial ^ params[k*HASH_WIDTH +: HASH_WIDTH];
            end
        end
    end

endmodule

// File: rtl/h3_hash_multi.sv
// NUM_HASHES parallel H3 hashes of one input word, two-stage XOR reduction,
// valid/ready on both sides, runtime-writable hash parameters.
// Optional macro H3_PARITY_EN adds a registered per-hash parity output.
module h3_hash_multi
    import h3_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int HASH_WIDTH  = DEF_HASH_WIDTH,
    parameter int NUM_HASHES  = DEF_NUM_HASHES,
    parameter int GROUP_SIZE  = DEF_GROUP_SIZE
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_we,
    input  logic [safe_clog2(NUM_HASHES)-1:0]   cfg_hash_sel,
    input  logic [safe_clog2(INPUT_WIDTH)-1:0]  cfg_bit_sel,
    input  logic [HASH_WIDTH-1:0]               cfg_value,
    input  logic                                inp_vld,
    output logic                                inp_rdy,
    input  logic [INPUT_WIDTH-1:0]              input_value,
    output logic                                outp_vld,
    input  logic                                outp_rdy,
    output logic [NUM_HASHES*HASH_WIDTH-1:0]    hash_result
`ifdef H3_PARITY_EN
    ,
    output logic [NUM_HASHES-1:0]               hash_parity
`endif
);

    localparam int N_GROUPS = (INPUT_WIDTH + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int PAD_W    = N_GROUPS * GROUP_SIZE;

    logic [HASH_WIDTH-1:0]            params      [NUM_HASHES][INPUT_WIDTH];
    logic [PAD_W*HASH_WIDTH-1:0]      par_flat    [NUM_HASHES];
    logic [PAD_W-1:0]                 in_pad;
    logic [HASH_WIDTH-1:0]            grp_partial [NUM_HASHES][N_GROUPS];
    logic [HASH_WIDTH-1:0]            s1_part     [NUM_HASHES][N_GROUPS];
    logic                             s1_vld;
    logic [NUM_HASHES*HASH_WIDTH-1:0] s2_next;
    logic                             s1_adv;
    logic                             s2_adv;
    logic                             cfg_hit;

    // Handshake: a word moves across an interface on a cycle where vld && rdy.
    // Each stage advances when it is empty or the stage after it is advancing,
    // so inp_rdy is purely combinational from outp_rdy and the two valid bits;
    // a full pipeline therefore buffers exactly two words under backpressure.
    assign s2_adv  = !outp_vld || outp_rdy;
    assign s1_adv  = !s1_vld || s2_adv;
    assign inp_rdy = s1_adv;

    // Out-of-range writes are dropped rather than aliased onto a real entry.
    assign cfg_hit = cfg_we
                  && (32'(cfg_hash_sel) < NUM_HASHES)
                  && (32'(cfg_bit_sel) < INPUT_WIDTH);

    // Parameter table; an input accepted alongside a write sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < NUM_HASHES; h++) begin
                for (int i = 0; i < INPUT_WIDTH; i++) begin
                    params[h][i] <= '0;
                end
            end
        end else if (cfg_hit) begin
            params[cfg_hash_sel][cfg_bit_sel] <= cfg_value;
        end
    end

    // Zero-extend input and flatten parameter rows so every group is full width.
    assign in_pad = PAD_W'(input_value);

    // Flatten each hash's parameter rows; padding rows stay zero.
    always_comb begin
        for (int h = 0; h < NUM_HASHES; h++) begin
            par_flat[h] = '0;
            for (int i = 0; i < INPUT_WIDTH; i++) begin
                par_flat[h][i*HASH_WIDTH +: HASH_WIDTH] = params[h][i];
            end
        end
    end

    for (genvar h = 0; h < NUM_HASHES; h++) begin : g_hash
        for (genvar g = 0; g < N_GROUPS; g++) begin : g_group
            h3_group_xor #(
                .HASH_WIDTH (HASH_WIDTH),
                .GROUP_SIZE (GROUP_SIZE)
            ) u_group_xor (
                .bits    (in_pad[g*GROUP_SIZE +: GROUP_SIZE]),
                .params  (par_flat[h][g*GROUP_SIZE*HASH_WIDTH +: GROUP_SIZE*HASH_WIDTH]),
                .partial (grp_partial[h][g])
            );
        end
    end

    // Stage 1: capture per-group partials when the stage can advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            for (int h = 0; h < NUM_HASHES; h++) begin
                for (int g = 0; g < N_GROUPS; g++) begin
                    s1_part[h][g] <= '0;
                end
            end
        end else if (s1_adv) begin
            s1_vld <= inp_vld;
            if (inp_vld) begin
                s1_part <= grp_partial;
            end
        end
    end

    // Stage 2 combine: fold all partials of each hash together.
    always_comb begin
        s2_next = '0;
        for (int h = 0; h < NUM_HASHES; h++) begin
            for (int g = 0; g < N_GROUPS; g++) begin
                s2_next[h*HASH_WIDTH +: HASH_WIDTH] =
                    s2_next[h*HASH_WIDTH +: HASH_WIDTH] ^ s1_part[h][g];
            end
        end
    end

    // Stage 2 register: result holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            outp_vld    <= 1'b0;
            hash_result <= '0;
        end else if (s2_adv) begin
            outp_vld <= s1_vld;
            if (s1_vld) begin
                hash_result <= s2_next;
            end
        end
    end

`ifdef H3_PARITY_EN
    logic [NUM_HASHES-1:0] par_next;

    // Parity of each next-cycle hash value.
    always_comb begin
        par_next = '0;
        for (int h = 0; h < NUM_HASHES; h++) begin
            par_next[h] = ^s2_next[h*HASH_WIDTH +: HASH_WIDTH];
        end
    end

    // Parity register shares the result register's load condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            hash_parity <= '0;
        end else if (s2_adv && s1_vld) begin
            hash_parity <= par_next;
        end
    end
`endif

endmodule

// File: tb/tb_h3_hash_multi.sv
// Bench for h3_hash_multi: directed scenarios with literal expectations plus a
// parameter-table model and expected-result queue checked on every negedge.
// Build with H3_PARITY_EN defined to also check hash_parity.
module tb_h3_hash_multi;
    import h3_pkg::*;

    localparam int IW  = DEF_INPUT_WIDTH;
    localparam int HW  = DEF_HASH_WIDTH;
    localparam int NH  = DEF_NUM_HASHES;
    localparam int HSW = safe_clog2(NH);
    localparam int BSW = safe_clog2(IW);

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst;
    logic cfg_we;
    logic [HSW-1:0] cfg_hash_sel;
    logic [BSW-1:0] cfg_bit_sel;
    logic [HW-1:0] cfg_value;
    logic inp_vld;
    logic inp_rdy;
    logic [IW-1:0] input_value;
    logic outp_vld;
    logic outp_rdy;
    logic [NH*HW-1:0] hash_result;
`ifdef H3_PARITY_EN
    logic [NH-1:0] hash_parity;
`endif

    always #5 clk = ~clk;

    h3_hash_multi dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_hash_sel (cfg_hash_sel),
        .cfg_bit_sel  (cfg_bit_sel),
        .cfg_value    (cfg_value),
        .inp_vld      (inp_vld),
        .inp_rdy      (inp_rdy),
        .input_value  (input_value),
        .outp_vld     (outp_vld),
        .outp_rdy     (outp_rdy),
        .hash_result  (hash_result)
`ifdef H3_PARITY_EN
        ,
        .hash_parity  (hash_parity)
`endif
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit lat_chk = 1'b0;
    bit saw_rdy_low = 1'b0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- reference model ----------------
    hash_t m_params [NH][IW];
    logic [NH*HW-1:0] exp_q [$];
    int acc_q [$];
    bit stall_prev = 1'b0;
    logic [NH*HW-1:0] stall_hash;

    function automatic logic [NH*HW-1:0] model_hash(input logic [IW-1:0] v);
        logic [NH*HW-1:0] r = '0;
        for (int h = 0; h < NH; h++) begin
            for (int i = 0; i < IW; i++) begin
                if (v[i]) r[h*HW +: HW] = r[h*HW +: HW] ^ m_params[h][i];
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        logic [NH*HW-1:0] e;
        int a;
        cycle++;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            stall_prev = 1'b0;
            for (int h = 0; h < NH; h++)
                for (int i = 0; i < IW; i++) m_params[h][i] = '0;
        end else begin
            // Two words occupy the pipeline and the consumer stalls -> no room.
            check_eq("inp_rdy_rule", inp_rdy, !(exp_q.size() >= 2 && !outp_rdy));
            if (!inp_rdy) saw_rdy_low = 1'b1;
            if (stall_prev) begin
                check_eq("stall_vld_hold", outp_vld, 1'b1);
                check_eq("stall_result_hold", hash_result, stall_hash);
            end
            if (outp_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: actual=%0h required=no valid output", hash_result);
                end else if (outp_rdy) begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check_eq("stream_result", hash_result, e);
`ifdef H3_PARITY_EN
                    for (int h = 0; h < NH; h++)
                        check_eq("stream_parity", hash_parity[h], ^e[h*HW +: HW]);
`endif
                    if (lat_chk) check_eq("latency", cycle - a, 2);
                end
            end
            stall_prev = outp_vld && !outp_rdy;
            stall_hash = hash_result;
            if (inp_vld && inp_rdy) begin
                exp_q.push_back(model_hash(input_value));
                acc_q.push_back(cycle);
            end
            if (cfg_we && int'(cfg_hash_sel) < NH && int'(cfg_bit_sel) < IW)
                m_params[cfg_hash_sel][cfg_bit_sel] = cfg_value;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input int h, input int b, input int v);
        cfg_we       = 1'b1;
        cfg_hash_sel = h[HSW-1:0];
        cfg_bit_sel  = b[BSW-1:0];
        cfg_value    = v[HW-1:0];
        tick();
        cfg_we = 1'b0;
    endtask

    // Presents a word and holds it until accepted; leaves inp_vld asserted.
    task automatic send(input logic [IW-1:0] v);
        bit acc;
        int n;
        inp_vld = 1'b1;
        input_value = v;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = inp_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_eq("send_timeout", 0, 1);
    endtask

    task automatic wait_result(output logic [NH*HW-1:0] r);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        r = '0;
        while (!got && n < 30) begin
            @(negedge clk);
            if (outp_vld && outp_rdy) begin
                got = 1'b1;
                r = hash_result;
            end
            n++;
        end
        @(posedge clk);
        #1;
        if (!got) check_eq("result_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [NH*HW-1:0] r;
        logic [NH*HW-1:0] r_before;
        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_hash_sel = '0;
        cfg_bit_sel = '0;
        cfg_value = '0;
        inp_vld = 1'b0;
        input_value = '0;
        outp_rdy = 1'b0;
        tick();
        do_reset();

        // Reset state
        @(negedge clk);
        check_eq("reset_outp_vld", outp_vld, 1'b0);
        check_eq("reset_hash_result", hash_result, 0);
        check_eq("reset_inp_rdy", inp_rdy, 1'b1);
`ifdef H3_PARITY_EN
        check_eq("reset_parity", hash_parity, 0);
`endif
        tick();

        // Basic hash
        cfg_write(0, 0, 108);
        cfg_write(0, 1, 237);
        cfg_write(0, 2, 82);
        cfg_write(0, 3, 251);
        cfg_write(1, 0, 51);
        outp_rdy = 1'b1;
        lat_chk = 1'b1;
        send(28'h1);
        send(28'hF);
        inp_vld = 1'b0;
        wait_result(r);
        check_eq("basic1_h0", r[7:0], 8'd108);
        check_eq("basic1_h1", r[15:8], 8'd51);
        wait_result(r);
        check_eq("basic2_h0", r[7:0], 8'd40);
        check_eq("basic2_h1", r[15:8], 8'd51);

        // Streaming with random parameters
        for (int h = 0; h < NH; h++)
            for (int i = 0; i < IW; i++) cfg_write(h, i, $urandom_range(0, 255));
        for (int k = 0; k < 32; k++) send(IW'($urandom()));
        inp_vld = 1'b0;
        drain();

        // Backpressure: consumer stalls for 5 cycles mid-stream
        lat_chk = 1'b0;
        saw_rdy_low = 1'b0;
        fork
            begin
                for (int k = 0; k < 12; k++) send(IW'($urandom()));
                inp_vld = 1'b0;
            end
            begin
                repeat (3) tick();
                outp_rdy = 1'b0;
                repeat (5) tick();
                outp_rdy = 1'b1;
            end
        join
        drain();
        check_eq("bp_inp_rdy_fell", saw_rdy_low, 1'b1);

        // Config race: write and accept in the same cycle
        do_reset();
        outp_rdy = 1'b1;
        lat_chk = 1'b1;
        cfg_write(0, 0, 108);
        cfg_we = 1'b1;
        cfg_hash_sel = '0;
        cfg_bit_sel = '0;
        cfg_value = 8'd200;
        inp_vld = 1'b1;
        input_value = 28'h1;
        @(negedge clk);
        check_eq("race_inp_rdy", inp_rdy, 1'b1);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        send(28'h1);
        inp_vld = 1'b0;
        wait_result(r);
        check_eq("race_old_value", r[7:0], 8'd108);
        wait_result(r);
        check_eq("race_new_value", r[7:0], 8'd200);

        // Reset with two words in flight
        lat_chk = 1'b0;
        outp_rdy = 1'b0;
        send(28'h1);
        send(28'h3);
        inp_vld = 1'b0;
        tick();
        do_reset();
        @(negedge clk);
        check_eq("midrst_outp_vld", outp_vld, 1'b0);
        check_eq("midrst_inp_rdy", inp_rdy, 1'b1);
        @(posedge clk);
        #1;
        outp_rdy = 1'b1;
        send(28'h1);
        inp_vld = 1'b0;
        wait_result(r);
        check_eq("midrst_hash_zero", r, 0);

        // Illegal write leaves parameters untouched
        cfg_write(0, 5, 77);
        cfg_write(1, 27, 99);
        send({IW{1'b1}});
        inp_vld = 1'b0;
        wait_result(r_before);
        check_eq("ones_h0", r_before[7:0], 8'd77);
        check_eq("ones_h1", r_before[15:8], 8'd99);
        cfg_write(0, 28, 8'hAA);
        cfg_write(1, 31, 8'h55);
        send({IW{1'b1}});
        inp_vld = 1'b0;
        wait_result(r);
        check_eq("illegal_write_ignored", r, r_before);

        repeat (4) tick();
        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("FAIL global_timeout: actual=still running required=finished");
        $fatal(1, "timeout");
    end

endmodule
